// File: rtl/alux_unit.sv
// alux_unit: multi-cycle arithmetic/logic unit.
// Single-step ops complete one edge after start; MUL (shift-add) and
// DIV (restoring) take WIDTH edges. A registered alux_done pulse marks each
// completion. result/error hold their values between completions.
module alux_unit #(
    parameter int WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           opr,
    input  logic [WIDTH-1:0]     dataa,
    input  logic [WIDTH-1:0]     datab,
    input  logic                 abort,
    output logic                 busy,
    output logic                 alux_done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 error
);

    localparam int AW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD     = 4'b0000;
    localparam logic [3:0] OP_SUB     = 4'b0001;
    localparam logic [3:0] OP_MUL     = 4'b0010;
    localparam logic [3:0] OP_DIV     = 4'b0011;
    localparam logic [3:0] OP_AND     = 4'b0100;
    localparam logic [3:0] OP_OR      = 4'b0110;
    localparam logic [3:0] OP_XOR     = 4'b1000;
    localparam logic [3:0] OP_MAX     = 4'b1001;
    localparam logic [3:0] OP_ABSDIFF = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [3:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [AW-1:0]        acc_q;
    logic [CW-1:0]        cnt_q;

    logic [AW-1:0]        mul_step;
    logic [AW-1:0]        div_shift;
    logic [AW-1:0]        div_step;
    logic [AW-1:0]        step;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   single_res;
    logic                 single_err;
    logic                 multi;
    logic                 last_iter;
    logic                 finish;

    // Iteration datapath and single-step results from the latched operands.
    // MUL: acc = {partial_hi, multiplier}, add A to the high part when the
    // multiplier LSB is set, then shift right.
    // DIV: acc = {remainder, quotient/dividend}, shift left, subtract B from
    // the high part when it fits and set the new quotient bit.
    always_comb begin
        mul_step = acc_q;
        if (acc_q[0]) begin
            mul_step[AW-1:WIDTH] = acc_q[AW-1:WIDTH] + {1'b0, a_q};
        end
        mul_step = mul_step >> 1;

        div_shift = acc_q << 1;
        div_step  = div_shift;
        if (div_shift[AW-1:WIDTH] >= {1'b0, b_q}) begin
            div_step[AW-1:WIDTH] = div_shift[AW-1:WIDTH] - {1'b0, b_q};
            div_step[0]          = 1'b1;
        end

        sum  = {1'b0, a_q} + {1'b0, b_q};
        diff = {1'b0, a_q} - {1'b0, b_q};

        single_res = '0;
        single_err = 1'b0;
        case (op_q)
            OP_ADD:     single_res[WIDTH:0]   = sum;
            OP_SUB:     single_res[WIDTH:0]   = diff;
            OP_AND:     single_res[WIDTH-1:0] = a_q & b_q;
            OP_OR:      single_res[WIDTH-1:0] = a_q | b_q;
            OP_XOR:     single_res[WIDTH-1:0] = a_q ^ b_q;
            OP_MAX:     single_res[WIDTH-1:0] = (a_q >= b_q) ? a_q : b_q;
            OP_ABSDIFF: single_res[WIDTH-1:0] = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
            OP_MUL:     single_res = '0;
            OP_DIV: begin
                // only reached as a single step when the divisor is zero
                single_res = '1;
                single_err = 1'b1;
            end
            default:    single_err = 1'b1;
        endcase

        multi     = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
        step      = (op_q == OP_MUL) ? mul_step : div_step;
        last_iter = (cnt_q == CW'(WIDTH - 1));
        finish    = multi ? last_iter : 1'b1;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort only matters in EXEC and beats completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_EXEC;
            S_EXEC: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (finish) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

    // Operand capture, iteration, and registered result/error/done.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result    <= '0;
            error     <= 1'b0;
            alux_done <= 1'b0;
        end else begin
            alux_done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= opr;
                        a_q   <= dataa;
                        b_q   <= datab;
                        cnt_q <= '0;
                        acc_q <= (opr == OP_DIV) ? AW'(dataa) : AW'(datab);
                    end
                end
                S_EXEC: begin
                    if (!abort) begin
                        if (multi) begin
                            acc_q <= step;
                            cnt_q <= cnt_q + CW'(1);
                        end
                        if (finish) begin
                            result    <= multi ? step[2*WIDTH-1:0] : single_res;
                            error     <= multi ? 1'b0 : single_err;
                            alux_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
